// File: rtl/sdram_arb_pkg.sv
// Shared command encodings, arbiter states and burst lengths for the SDRAM arbiter.
// No logic; types and constants only.
// Imported by sdram_arbiter and its testbench-facing sub-blocks.
package sdram_arb_pkg;

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_WR256 = 2'b01;
  localparam logic [1:0] CMD_RD32  = 2'b10;
  localparam logic [1:0] CMD_RD256 = 2'b11;

  localparam int VID_BEATS   = 16;
  localparam int CACHE_BEATS = 128;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CMD        = 2'd1,
    XFER_VID   = 2'd2,
    XFER_CACHE = 2'd3
  } state_e;

endpackage

// File: rtl/vq_packer.sv
// Packs pairs of 16-bit SDRAM read beats into 32-bit video queue words.
// Latency: word and strobe appear one cycle after the odd beat.
// Backpressure: none; the video queue must accept every strobe.
module vq_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        beat_vld,
  input  logic        beat_odd,
  input  logic [15:0] beat_dat,
  output logic [31:0] vq_data,
  output logic        vq_wren
);

  logic [15:0] low;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      low     <= '0;
      vq_data <= '0;
      vq_wren <= 1'b0;
    end else begin
      vq_wren <= beat_vld && beat_odd;
      if (beat_vld && !beat_odd)
        low <= beat_dat;
      if (beat_vld && beat_odd)
        vq_data <= {beat_dat, low};
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Arbitrates video refill, cache write-back and cache fill onto one SDRAM command port.
// Latency: grant one cycle after IDLE sees a request; command held until acknowledged.
// Backpressure: sys_cmd is held until sys_cmd_ack matches; data beats are never stalled.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int VID_LAST   = 19199,
  parameter int VID_STREAK = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vid_low,
  input  logic        cache_wr,
  input  logic        cache_rd,
  input  logic [17:0] waddr,
  input  logic [16:0] line_addr,
  output logic [1:0]  sys_cmd,
  output logic [22:0] sys_addr,
  input  logic [1:0]  sys_cmd_ack,
  input  logic        sys_rd_data_valid,
  input  logic        sys_wr_data_valid,
  input  logic [15:0] sys_dout,
  output logic [31:0] vq_data,
  output logic        vq_wren,
  output logic        cache_write_data,
  output logic        cache_read_data,
  output logic [18:0] vidadr
);

  localparam logic [7:0]  STREAK_MAX = 8'(VID_STREAK);
  localparam logic [6:0]  VID_LAST_BEAT   = 7'(VID_BEATS - 1);
  localparam logic [6:0]  CACHE_LAST_BEAT = 7'(CACHE_BEATS - 1);
  localparam logic [18:0] VIDADR_LAST = 19'(VID_LAST);

  state_e      state, state_n;
  logic [1:0]  sys_cmd_n;
  logic [1:0]  cur_cmd, cur_cmd_n;
  logic [6:0]  beat, beat_n;
  logic [7:0]  streak, streak_n;
  logic [18:0] vidadr_n;
  logic        cache_req;
  logic        xfer_vld;

  // waddr[17] lies outside the 8M-word SDRAM window.
  logic unused_waddr_msb;
  assign unused_waddr_msb = waddr[17];

  assign cache_req = cache_wr | cache_rd;
  assign xfer_vld  = (cur_cmd == CMD_WR256) ? sys_wr_data_valid : sys_rd_data_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sys_cmd <= CMD_NOP;
      cur_cmd <= CMD_NOP;
      beat    <= '0;
      streak  <= '0;
      vidadr  <= '0;
    end else begin
      state   <= state_n;
      sys_cmd <= sys_cmd_n;
      cur_cmd <= cur_cmd_n;
      beat    <= beat_n;
      streak  <= streak_n;
      vidadr  <= vidadr_n;
    end
  end

  always_comb begin
    state_n   = state;
    sys_cmd_n = sys_cmd;
    cur_cmd_n = cur_cmd;
    beat_n    = beat;
    streak_n  = streak;
    vidadr_n  = vidadr;
    case (state)
      IDLE: begin
        // A cache request that has waited out the video streak beats video.
        if (cache_req && (!vid_low || streak == STREAK_MAX)) begin
          sys_cmd_n = cache_wr ? CMD_WR256 : CMD_RD256;
          streak_n  = '0;
          state_n   = CMD;
        end else if (vid_low) begin
          sys_cmd_n = CMD_RD32;
          if (cache_req && streak != STREAK_MAX)
            streak_n = streak + 8'd1;
          state_n = CMD;
        end
      end
      CMD: begin
        if (sys_cmd_ack == sys_cmd) begin
          sys_cmd_n = CMD_NOP;
          cur_cmd_n = sys_cmd;
          beat_n    = '0;
          if (sys_cmd == CMD_RD32) begin
            state_n  = XFER_VID;
            vidadr_n = (vidadr == VIDADR_LAST) ? '0 : vidadr + 19'd1;
          end else begin
            state_n = XFER_CACHE;
          end
        end
      end
      XFER_VID: begin
        if (sys_rd_data_valid) begin
          beat_n = beat + 7'd1;
          if (beat == VID_LAST_BEAT) begin
            beat_n  = '0;
            state_n = IDLE;
          end
        end
      end
      XFER_CACHE: begin
        if (xfer_vld) begin
          beat_n = beat + 7'd1;
          if (beat == CACHE_LAST_BEAT) begin
            beat_n  = '0;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    case (sys_cmd)
      CMD_WR256: sys_addr = {waddr[16:0], 6'b0};
      CMD_RD32:  sys_addr = {1'b1, vidadr, 3'b0};
      CMD_RD256: sys_addr = {line_addr, 6'b0};
      default:   sys_addr = '0;
    endcase
  end

  assign cache_write_data = (state == XFER_CACHE) && (cur_cmd == CMD_RD256) && sys_rd_data_valid;
  assign cache_read_data  = (state == XFER_CACHE) && (cur_cmd == CMD_WR256) && sys_wr_data_valid;

  vq_packer u_vq_packer (
    .clk      (clk),
    .rst      (rst),
    .beat_vld (state == XFER_VID && sys_rd_data_valid),
    .beat_odd (beat[0]),
    .beat_dat (sys_dout),
    .vq_data  (vq_data),
    .vq_wren  (vq_wren)
  );

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: a behavioural arbitration/packing model predicts
// each grant and video word; a negedge monitor pops and compares what the DUT presents.
module tb_sdram_arbiter;

  localparam int VID_LAST   = 19199;
  localparam int VID_STREAK = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        vid_low, cache_wr, cache_rd;
  logic [17:0] waddr;
  logic [16:0] line_addr;
  logic [1:0]  sys_cmd, sys_cmd_ack;
  logic [22:0] sys_addr;
  logic        sys_rd_data_valid, sys_wr_data_valid;
  logic [15:0] sys_dout;
  logic [31:0] vq_data;
  logic        vq_wren;
  logic        cache_write_data, cache_read_data;
  logic [18:0] vidadr;

  sdram_arbiter #(.VID_LAST(VID_LAST), .VID_STREAK(VID_STREAK)) dut (
    .clk               (clk),
    .rst               (rst),
    .vid_low           (vid_low),
    .cache_wr          (cache_wr),
    .cache_rd          (cache_rd),
    .waddr             (waddr),
    .line_addr         (line_addr),
    .sys_cmd           (sys_cmd),
    .sys_addr          (sys_addr),
    .sys_cmd_ack       (sys_cmd_ack),
    .sys_rd_data_valid (sys_rd_data_valid),
    .sys_wr_data_valid (sys_wr_data_valid),
    .sys_dout          (sys_dout),
    .vq_data           (vq_data),
    .vq_wren           (vq_wren),
    .cache_write_data  (cache_write_data),
    .cache_read_data   (cache_read_data),
    .vidadr            (vidadr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  cmd;
    logic [22:0] addr;
  } exp_cmd_t;

  exp_cmd_t    cmd_q[$];
  logic [31:0] vq_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cnt_cwd = 0;
  int          cnt_crd = 0;
  int          streak_m = 0;
  int          vid_m = 0;
  logic [1:0]  prev_cmd = 2'b00;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s", name);
  endtask

  // Reference arbitration: video first, write-back before fill, but a cache request
  // that has already let VID_STREAK video bursts through gets the next slot.
  task automatic model_grant(input bit v, input bit w, input bit r, output logic [1:0] c);
    exp_cmd_t e;
    bit pend;
    pend = w | r;
    c = 2'b00;
    if (pend && (!v || streak_m == VID_STREAK)) begin
      streak_m = 0;
      c = w ? 2'b01 : 2'b11;
    end else if (v) begin
      if (pend && streak_m < VID_STREAK) streak_m++;
      c = 2'b10;
    end
    e.cmd = c;
    case (c)
      2'b01:   e.addr = {waddr[16:0], 6'b0};
      2'b11:   e.addr = {line_addr, 6'b0};
      default: e.addr = {1'b1, 19'(vid_m), 3'b000};
    endcase
    if (c == 2'b10) vid_m = (vid_m == VID_LAST) ? 0 : vid_m + 1;
    if (c != 2'b00) cmd_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_cmd_t e;
    if (rst) begin
      prev_cmd = 2'b00;
    end else begin
      if (sys_cmd != 2'b00 && prev_cmd == 2'b00) begin
        if (cmd_q.size() == 0) begin
          fail("unexpected_grant");
        end else begin
          e = cmd_q.pop_front();
          check("grant_cmd", 64'(sys_cmd), 64'(e.cmd));
          check("grant_addr", 64'(sys_addr), 64'(e.addr));
        end
      end
      prev_cmd = sys_cmd;
      if (vq_wren) begin
        if (vq_q.size() == 0) fail("unexpected_vq_wren");
        else check("vq_data", 64'(vq_data), 64'(vq_q.pop_front()));
      end
      if (cache_write_data) cnt_cwd++;
      if (cache_read_data)  cnt_crd++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Plays the SDRAM controller for one transaction.
  task automatic serve(input int lat, input bit mism, input bit drop, input bit seq,
                       input int rst_after, output logic [1:0] gc, output logic [22:0] ga);
    logic [1:0]  pc;
    logic [15:0] d, lo;
    bit ok;
    int nb;
    model_grant(vid_low, cache_wr, cache_rd, pc);
    ok = 0;
    gc = 2'b00;
    ga = '0;
    lo = '0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (sys_cmd != 2'b00) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      fail("grant_timeout");
      return;
    end
    gc = sys_cmd;
    ga = sys_addr;
    if (drop) begin
      vid_low = 0; cache_wr = 0; cache_rd = 0;
    end
    cnt_cwd = 0;
    cnt_crd = 0;
    // Stray data-valid pulses while the command waits must be ignored.
    for (int i = 0; i < lat; i++) begin
      sys_rd_data_valid = 1'($urandom_range(0, 1));
      sys_wr_data_valid = 1'($urandom_range(0, 1));
      sys_dout = 16'($urandom);
      tick();
      check("cmd_held", 64'(sys_cmd), 64'(gc));
    end
    sys_rd_data_valid = 0;
    sys_wr_data_valid = 0;
    if (mism) begin
      sys_cmd_ack = gc ^ 2'b01;
      tick();
      check("bad_ack_ignored", 64'(sys_cmd), 64'(gc));
    end
    sys_cmd_ack = gc;
    tick();
    sys_cmd_ack = 2'b00;
    check("cmd_cleared_after_ack", 64'(sys_cmd), 64'd0);
    nb = (gc == 2'b10) ? 16 : 128;
    for (int b = 0; b < nb; b++) begin
      if ($urandom_range(0, 3) == 0) tick();
      d = seq ? 16'(b + 1) : 16'($urandom);
      sys_dout = d;
      if (gc == 2'b10) begin
        if (b % 2 == 0) lo = d;
        else vq_q.push_back({d, lo});
        sys_rd_data_valid = 1;
      end else if (gc == 2'b11) begin
        sys_rd_data_valid = 1;
      end else begin
        sys_wr_data_valid = 1;
      end
      tick();
      sys_rd_data_valid = 0;
      sys_wr_data_valid = 0;
      if (b + 1 == rst_after) begin
        rst = 1;
        #1;
        check("rst_sys_cmd", 64'(sys_cmd), 64'd0);
        check("rst_vidadr", 64'(vidadr), 64'd0);
        check("rst_vq_wren", 64'(vq_wren), 64'd0);
        check("rst_vq_data", 64'(vq_data), 64'd0);
        check("rst_sys_addr", 64'(sys_addr), 64'd0);
        rst = 0;
        vid_m = 0;
        streak_m = 0;
        vq_q.delete();
        return;
      end
    end
    check("fill_beats", 64'(cnt_cwd), (gc == 2'b11) ? 64'd128 : 64'd0);
    check("wb_beats", 64'(cnt_crd), (gc == 2'b01) ? 64'd128 : 64'd0);
    check("vidadr", 64'(vidadr), 64'(vid_m));
  endtask

  initial begin
    logic [1:0]  gc;
    logic [22:0] ga;
    logic [1:0]  order [4];
    bit v, w, r;
    order[0] = 2'b10; order[1] = 2'b10; order[2] = 2'b01; order[3] = 2'b10;
    rst = 1; vid_low = 0; cache_wr = 0; cache_rd = 0;
    waddr = '0; line_addr = '0; sys_cmd_ack = 0;
    sys_rd_data_valid = 0; sys_wr_data_valid = 0; sys_dout = '0;
    repeat (3) tick();
    check("reset_sys_cmd", 64'(sys_cmd), 64'd0);
    check("reset_sys_addr", 64'(sys_addr), 64'd0);
    check("reset_vidadr", 64'(vidadr), 64'd0);
    check("reset_vq_wren", 64'(vq_wren), 64'd0);
    check("reset_vq_data", 64'(vq_data), 64'd0);
    check("reset_cache_wd", 64'(cache_write_data), 64'd0);
    check("reset_cache_rd", 64'(cache_read_data), 64'd0);
    rst = 0;
    tick();

    // First video burst with counting data
    vid_low = 1;
    serve(3, 0, 1, 1, 0, gc, ga);
    check("first_vid_addr", 64'(ga), 64'h400000);
    check("first_vidadr", 64'(vidadr), 64'd1);

    // Mismatched acknowledge
    vid_low = 1;
    serve(1, 1, 1, 0, 0, gc, ga);

    // Everything requested at once, video held
    vid_low = 1; cache_rd = 1; cache_wr = 1;
    waddr = 18'($urandom); line_addr = 17'($urandom);
    for (int i = 0; i < 4; i++) begin
      serve(1, 0, i == 3, 0, 0, gc, ga);
      check("streak_order", 64'(gc), 64'(order[i]));
      if (i == 2) check("wb_addr", 64'(ga), 64'({waddr[16:0], 6'b0}));
    end

    // Cache fill
    cache_rd = 1; line_addr = 17'h1ABCD;
    serve(2, 0, 1, 0, 0, gc, ga);
    check("fill_addr", 64'(ga), 64'h6AF340);

    // Random request mixes
    for (int k = 0; k < 12; k++) begin
      do begin
        v = 1'($urandom_range(0, 1));
        w = 1'($urandom_range(0, 1));
        r = 1'($urandom_range(0, 1));
      end while (!(v | w | r));
      waddr = 18'($urandom); line_addr = 17'($urandom);
      vid_low = v; cache_wr = w; cache_rd = r;
      serve($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1, 0, 0, gc, ga);
    end

    // Video index wrap
    force dut.vidadr = 19'(VID_LAST);
    repeat (2) tick();
    release dut.vidadr;
    vid_m = VID_LAST;
    vid_low = 1;
    serve(1, 0, 1, 0, 0, gc, ga);
    check("wrap_addr_last", 64'(ga), 64'({1'b1, 19'(VID_LAST), 3'b000}));
    check("wrap_vidadr", 64'(vidadr), 64'd0);
    vid_low = 1;
    serve(1, 0, 1, 0, 0, gc, ga);
    check("wrap_next_addr", 64'(ga), 64'h400000);

    // Reset in the middle of a video burst, then a clean burst
    vid_low = 1;
    serve(1, 0, 1, 0, 5, gc, ga);
    tick();
    vid_low = 1;
    serve(1, 0, 1, 1, 0, gc, ga);
    check("post_rst_addr", 64'(ga), 64'h400000);

    repeat (4) tick();
    check("cmd_queue_drained", 64'(cmd_q.size()), 64'd0);
    check("vq_queue_drained", 64'(vq_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
